// File: rtl/row_vector_feeder_pkg.sv
// Shared dot-product definitions: chunk geometry defaults and feeder FSM encoding.
package row_vector_feeder_pkg;

  localparam int DP_NI            = 8;
  localparam int DP_ELEMENT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/row_vector_feeder_if.sv
// Row/vector chunk memory read bus; the feeder drives addresses, memories return chunks.
interface row_vector_feeder_if #(
  parameter int NI            = 8,
  parameter int ELEMENT_WIDTH = 32,
  parameter int ADDR_WIDTH    = 10
) ();
  logic [ADDR_WIDTH-1:0]       row_mem_addr;
  logic [NI*ELEMENT_WIDTH-1:0] row_mem_data;
  logic [ADDR_WIDTH-1:0]       vec_mem_addr;
  logic [NI*ELEMENT_WIDTH-1:0] vec_mem_data;

  modport master (output row_mem_addr, output vec_mem_addr,
                  input  row_mem_data, input  vec_mem_data);
  modport slave  (input  row_mem_addr, input  vec_mem_addr,
                  output row_mem_data, output vec_mem_data);
endinterface

// File: rtl/row_vector_feeder.sv
// Streams row/vector chunk pairs to the dot-product unit and writes finished row results.
//   state     | meaning
//   ST_IDLE   | waiting for start
//   ST_ISSUE  | one row/vector address pair per cycle
//   ST_DRAIN  | all addresses issued, collecting remaining row results
//   ST_FINISH | one cycle; done pulses on the following cycle
module row_vector_feeder
  import row_vector_feeder_pkg::*;
#(
  parameter int NI            = DP_NI,
  parameter int ELEMENT_WIDTH = DP_ELEMENT_WIDTH,
  parameter int ADDR_WIDTH    = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [15:0]                 no_of_rows,
  input  logic [31:0]                 no_of_multiples,
  row_vector_feeder_if.master         mem,
  output logic [NI*ELEMENT_WIDTH-1:0] a,
  output logic [NI*ELEMENT_WIDTH-1:0] p,
  output logic                        start_row_by_vector,
  input  logic [ELEMENT_WIDTH-1:0]    result,
  input  logic                        decoder_read_now,
  output logic                        res_wr_en,
  output logic [ADDR_WIDTH-1:0]       res_wr_addr,
  output logic [ELEMENT_WIDTH-1:0]    res_wr_data,
  output logic                        busy,
  output logic                        done
);

  feeder_state_t state_q, state_next;

  logic [15:0] rows_q, row_q, res_cnt_q, res_cnt_next;
  logic [31:0] mult_q, chunk_q;
  logic        chunk_last, last_issue, capture;

  assign chunk_last   = (chunk_q == mult_q - 32'd1);
  assign last_issue   = chunk_last && (row_q == rows_q - 16'd1);
  assign capture      = decoder_read_now && ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));
  assign res_cnt_next = capture ? res_cnt_q + 16'd1 : res_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_next;
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      ST_IDLE:
        if (start) begin
          if ((no_of_rows == 16'd0) || (no_of_multiples == 32'd0)) state_next = ST_FINISH;
          else                                                      state_next = ST_ISSUE;
        end
      ST_ISSUE:  if (last_issue) state_next = ST_DRAIN;
      // a count already complete on entry still exits here on the first DRAIN cycle
      ST_DRAIN:  if (res_cnt_next >= rows_q) state_next = ST_FINISH;
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rows_q              <= '0;
      mult_q              <= '0;
      row_q               <= '0;
      chunk_q             <= '0;
      res_cnt_q           <= '0;
      mem.row_mem_addr    <= '0;
      mem.vec_mem_addr    <= '0;
      a                   <= '0;
      p                   <= '0;
      start_row_by_vector <= 1'b0;
      res_wr_en           <= 1'b0;
      res_wr_addr         <= '0;
      res_wr_data         <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
    end else begin
      start_row_by_vector <= (state_q == ST_ISSUE);
      res_wr_en           <= capture;
      done                <= (state_q == ST_FINISH);
      busy                <= (state_next == ST_ISSUE) || (state_next == ST_DRAIN);

      if (state_q == ST_ISSUE) begin
        a <= mem.row_mem_data;
        p <= mem.vec_mem_data;
      end

      if (capture) begin
        res_wr_data <= result;
        res_wr_addr <= ADDR_WIDTH'(res_cnt_q);
        res_cnt_q   <= res_cnt_next;
      end

      if ((state_q == ST_IDLE) && start) begin
        rows_q           <= no_of_rows;
        mult_q           <= no_of_multiples;
        row_q            <= '0;
        chunk_q          <= '0;
        res_cnt_q        <= '0;
        mem.row_mem_addr <= '0;
        mem.vec_mem_addr <= '0;
      end

      // row address is row*multiples+chunk, which is simply a running count
      if ((state_q == ST_ISSUE) && !last_issue) begin
        mem.row_mem_addr <= mem.row_mem_addr + ADDR_WIDTH'(1);
        if (chunk_last) begin
          chunk_q          <= '0;
          mem.vec_mem_addr <= '0;
          row_q            <= row_q + 16'd1;
        end else begin
          chunk_q          <= chunk_q + 32'd1;
          mem.vec_mem_addr <= ADDR_WIDTH'(chunk_q + 32'd1);
        end
      end
    end
  end

endmodule
